// File: rtl/bcd_cnt_pkg.sv
// Shared constants and helpers for the cascaded BCD modulo counter.
//   BCD_W / BCD_MAX : digit width and largest legal digit value
//   bcd_word_t      : widest supported packed BCD word (4 digits)
//   digit_ctl_t     : per-digit control bundle driven by the top level
//   to_bcd()        : integer -> packed BCD constant (builds the terminal count)
//   bcd_valid()     : every digit <= 9
package bcd_cnt_pkg;

  localparam int BCD_W      = 4;
  localparam int BCD_MAX    = 9;
  localparam int MAX_DIGITS = 4;

  typedef logic [BCD_W*MAX_DIGITS-1:0] bcd_word_t;

  // Per-digit control. clr > load > inc/dec inside the digit.
  typedef struct packed {
    logic clr;
    logic load;
    logic inc;
    logic dec;
  } digit_ctl_t;

  // Digits above 'digits' are left zero so the result can be sliced down.
  function automatic bcd_word_t to_bcd(int v, int digits);
    bcd_word_t r;
    int        t;
    r = '0;
    t = v;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < digits) begin
        r[i*BCD_W +: BCD_W] = BCD_W'(t % 10);
        t = t / 10;
      end
    end
    return r;
  endfunction

  function automatic logic bcd_valid(bcd_word_t value);
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (value[i*BCD_W +: BCD_W] > BCD_W'(BCD_MAX)) return 1'b0;
    end
    return 1'b1;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit register (0..9) with clear, parallel load and +/-1 step.
//   clk, rst   : clock, asynchronous active-high reset
//   ctl        : clr / load / inc / dec controls (priority in that order)
//   load_val   : digit value taken on load
//   d          : current digit
//   carry_out  : inc requested while at 9 (digit wraps to 0)
//   borrow_out : dec requested while at 0 (digit wraps to 9)
module bcd_digit
  import bcd_cnt_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  digit_ctl_t       ctl,
  input  logic [BCD_W-1:0] load_val,
  output logic [BCD_W-1:0] d,
  output logic             carry_out,
  output logic             borrow_out
);

  localparam logic [BCD_W-1:0] DMAX = BCD_W'(BCD_MAX);

  logic step_ok;
  assign step_ok    = ~ctl.clr & ~ctl.load;
  assign carry_out  = step_ok & ctl.inc & (d == DMAX);
  assign borrow_out = step_ok & ctl.dec & (d == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           d <= '0;
    else if (ctl.clr)  d <= '0;
    else if (ctl.load) d <= load_val;
    else if (ctl.inc)  d <= (d == DMAX) ? '0 : d + 1'b1;
    else if (ctl.dec)  d <= (d == '0) ? DMAX : d - 1'b1;
  end

endmodule

// File: rtl/bcd_mod_counter.sv
// Cascaded BCD modulo counter, range 0..MODULUS-1, up/down.
//   clk, rst  : clock, asynchronous active-high reset
//   en, up    : count enable, direction (1 = increment)
//   clr       : synchronous clear (also clears load_err)
//   load      : synchronous parallel load of load_val (range checked)
//   load_val  : packed BCD, digit 0 in [3:0]
//   count     : packed BCD count, digit 0 in [3:0]
//   co        : combinational terminal-count strobe, feeds next stage en
//   load_err  : sticky, set by a rejected load
module bcd_mod_counter
  import bcd_cnt_pkg::*;
#(
  parameter int DIGITS  = 2,
  parameter int MODULUS = 60
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  clr,
  input  logic                  load,
  input  logic [BCD_W*DIGITS-1:0] load_val,
  output logic [BCD_W*DIGITS-1:0] count,
  output logic                  co,
  output logic                  load_err
);

  localparam int        W      = BCD_W*DIGITS;
  localparam bcd_word_t TERM_F = to_bcd(MODULUS-1, DIGITS);
  localparam logic [W-1:0] TERM = TERM_F[W-1:0];

  logic at_term, at_zero;
  assign at_term = (count == TERM);
  assign at_zero = (count == '0);

  // Load validation. For all-valid BCD words, unsigned vector order equals
  // decimal order, so "< MODULUS" is a plain compare against TERM.
  bcd_word_t load_ext;
  always_comb begin
    load_ext        = '0;
    load_ext[W-1:0] = load_val;
  end

  logic load_ok;
  assign load_ok = bcd_valid(load_ext) && (load_val <= TERM);

  // A count step only happens when neither clr nor load claims the cycle.
  logic step, wrap_up, wrap_dn;
  assign step    = en & ~clr & ~load;
  assign wrap_up = step &  up & at_term;
  assign wrap_dn = step & ~up & at_zero;

  assign co = step & (up ? at_term : at_zero);

  // Wraps reuse the digits' clear/load paths: up-wrap clears, down-wrap
  // loads TERM. Plain stepping enters digit 0 and ripples by carry/borrow.
  logic         dig_clr, dig_load;
  logic [W-1:0] dig_val;
  assign dig_clr  = clr | wrap_up;
  assign dig_load = (load & ~clr & load_ok) | wrap_dn;
  assign dig_val  = wrap_dn ? TERM : load_val;

  logic inc0, dec0;
  assign inc0 = step &  up & ~at_term;
  assign dec0 = step & ~up & ~at_zero;

  logic [DIGITS-1:0] inc, dec, carry, borrow;

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    if (i == 0) begin : g_lsd
      assign inc[i] = inc0;
      assign dec[i] = dec0;
    end else begin : g_chain
      assign inc[i] = carry[i-1];
      assign dec[i] = borrow[i-1];
    end

    digit_ctl_t ctl;
    assign ctl = '{clr: dig_clr, load: dig_load, inc: inc[i], dec: dec[i]};

    bcd_digit u_dig (
      .clk        (clk),
      .rst        (rst),
      .ctl        (ctl),
      .load_val   (dig_val[i*BCD_W +: BCD_W]),
      .d          (count[i*BCD_W +: BCD_W]),
      .carry_out  (carry[i]),
      .borrow_out (borrow[i])
    );
  end

  // The top digit never carries/borrows out: TERM/zero wraps intercept first.
  logic unused_msd;
  assign unused_msd = carry[DIGITS-1] | borrow[DIGITS-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  load_err <= 1'b0;
    else if (clr)             load_err <= 1'b0;
    else if (load & ~load_ok) load_err <= 1'b1;
  end

endmodule

// File: tb/tb_bcd_mod_counter.sv
module tb_bcd_mod_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, up, clr, load, co, load_err;
  logic [7:0] load_val, count;

  logic       c_en, c_up, c_load, m_co, h_co, m_err, h_err;
  logic [7:0] c_mv, c_hv, m_cnt, h_cnt;

  bcd_mod_counter #(.DIGITS(2), .MODULUS(60)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .count(count), .co(co), .load_err(load_err));

  bcd_mod_counter #(.DIGITS(2), .MODULUS(60)) u_min (
    .clk(clk), .rst(rst), .en(c_en), .up(c_up), .clr(1'b0), .load(c_load),
    .load_val(c_mv), .count(m_cnt), .co(m_co), .load_err(m_err));

  bcd_mod_counter #(.DIGITS(2), .MODULUS(24)) u_hr (
    .clk(clk), .rst(rst), .en(m_co), .up(c_up), .clr(1'b0), .load(c_load),
    .load_val(c_hv), .count(h_cnt), .co(h_co), .load_err(h_err));

  typedef struct {
    logic [7:0] cnt;
    logic       err;
    logic       co;
    logic [7:0] mc, hc;
    logic       mco, hco;
  } exp_t;

  exp_t q[$];
  int   vectors = 0, miscompares = 0;

  // Reference model: plain integers, modular arithmetic.
  int m, mm, hh;
  bit merr;

  function automatic logic [7:0] bcd2(int v);
    logic [7:0] r;
    r[3:0] = 4'(v % 10);
    r[7:4] = 4'(v / 10);
    return r;
  endfunction

  function automatic int dec2(logic [7:0] x);
    if (x[3:0] > 4'd9 || x[7:4] > 4'd9) return -1;
    return int'(x[7:4]) * 10 + int'(x[3:0]);
  endfunction

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drv(bit e, bit u, bit c, bit l, logic [7:0] lv,
                     bit ce, bit cu, bit cl, logic [7:0] cmv, logic [7:0] chv);
    exp_t x;
    int   v;
    @(negedge clk);
    en = e; up = u; clr = c; load = l; load_val = lv;
    c_en = ce; c_up = cu; c_load = cl; c_mv = cmv; c_hv = chv;

    x.co = e & !c & !l & (u ? (m == 59) : (m == 0));
    if (c) begin
      m = 0; merr = 0;
    end else if (l) begin
      v = dec2(lv);
      if (v >= 0 && v < 60) m = v; else merr = 1;
    end else if (e) begin
      m = u ? (m + 1) % 60 : (m + 59) % 60;
    end

    x.mco = ce & !cl & (cu ? (mm == 59) : (mm == 0));
    x.hco = x.mco & !cl & (cu ? (hh == 23) : (hh == 0));
    if (cl) begin
      mm = dec2(cmv); hh = dec2(chv);
    end else begin
      if (ce)    mm = cu ? (mm + 1) % 60 : (mm + 59) % 60;
      if (x.mco) hh = cu ? (hh + 1) % 24 : (hh + 23) % 24;
    end

    x.cnt = bcd2(m); x.err = merr; x.mc = bcd2(mm); x.hc = bcd2(hh);
    q.push_back(x);
  endtask

  task automatic idle();
    drv(0, 1, 0, 0, 8'h00, 0, 1, 0, 8'h00, 8'h00);
  endtask

  // Monitor: co sampled mid-cycle, registered outputs just after the edge.
  initial begin
    logic s_co, s_mco, s_hco;
    exp_t x;
    forever begin
      @(negedge clk); #2;
      s_co = co; s_mco = m_co; s_hco = h_co;
      @(posedge clk); #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        chk("co",       {7'd0, s_co},     {7'd0, x.co});
        chk("count",    count,            x.cnt);
        chk("load_err", {7'd0, load_err}, {7'd0, x.err});
        chk("min_co",   {7'd0, s_mco},    {7'd0, x.mco});
        chk("hr_co",    {7'd0, s_hco},    {7'd0, x.hco});
        chk("min",      m_cnt,            x.mc);
        chk("hr",       h_cnt,            x.hc);
        chk("casc_err", {6'd0, m_err, h_err}, 8'd0);
      end
    end
  end

  initial begin
    rst = 1; en = 0; up = 1; clr = 0; load = 0; load_val = 0;
    c_en = 0; c_up = 1; c_load = 0; c_mv = 0; c_hv = 0;
    m = 0; mm = 0; hh = 0; merr = 0;
    repeat (2) @(negedge clk);
    chk("rst_count", count, 8'h00);
    chk("rst_err",   {7'd0, load_err}, 8'd0);
    rst = 0;

    // Reset mid-count: count and sticky error lost immediately.
    drv(0, 1, 0, 1, 8'h37, 0, 1, 1, 8'h34, 8'h12);
    drv(0, 1, 0, 1, 8'h99, 0, 1, 0, 8'h00, 8'h00);
    @(posedge clk); #3;
    en = 0; load = 0; clr = 0; c_en = 0; c_load = 0;
    rst = 1; #1;
    chk("midrst_count", count, 8'h00);
    chk("midrst_err",   {7'd0, load_err}, 8'd0);
    chk("midrst_co",    {7'd0, co}, 8'd0);
    chk("midrst_min",   m_cnt, 8'h00);
    chk("midrst_hr",    h_cnt, 8'h00);
    m = 0; mm = 0; hh = 0; merr = 0;
    @(negedge clk); rst = 0;
    drv(1, 1, 0, 0, 8'h00, 0, 1, 0, 8'h00, 8'h00);   // -> 01

    // Up wrap 58 -> 59 -> 00.
    drv(0, 1, 0, 1, 8'h58, 0, 1, 0, 8'h00, 8'h00);
    repeat (3) drv(1, 1, 0, 0, 8'h00, 0, 1, 0, 8'h00, 8'h00);
    idle();

    // Down wrap 01 -> 00 -> 59, and digit borrow 40 -> 39.
    drv(0, 0, 0, 1, 8'h01, 0, 1, 0, 8'h00, 8'h00);
    repeat (2) drv(1, 0, 0, 0, 8'h00, 0, 1, 0, 8'h00, 8'h00);
    drv(0, 0, 0, 1, 8'h40, 0, 1, 0, 8'h00, 8'h00);
    drv(1, 0, 0, 0, 8'h00, 0, 1, 0, 8'h00, 8'h00);

    // Load checks and clear.
    drv(0, 1, 0, 1, 8'h42, 0, 1, 0, 8'h00, 8'h00);
    drv(0, 1, 0, 1, 8'h75, 0, 1, 0, 8'h00, 8'h00);
    drv(0, 1, 0, 1, 8'h3A, 0, 1, 0, 8'h00, 8'h00);
    drv(0, 1, 1, 0, 8'h00, 0, 1, 0, 8'h00, 8'h00);
    drv(0, 1, 0, 1, 8'h60, 0, 1, 0, 8'h00, 8'h00);

    // Priority.
    drv(0, 1, 0, 1, 8'h59, 0, 1, 0, 8'h00, 8'h00);
    drv(1, 1, 0, 1, 8'h10, 0, 1, 0, 8'h00, 8'h00);
    drv(1, 1, 1, 1, 8'h33, 0, 1, 0, 8'h00, 8'h00);
    drv(1, 0, 0, 0, 8'h00, 0, 1, 0, 8'h00, 8'h00);   // 00 down -> 59, co

    // Cascade: 23:59 -> 00:00 -> 00:01, then 00:00 down -> 23:59.
    drv(0, 1, 0, 0, 8'h00, 0, 1, 1, 8'h59, 8'h23);
    drv(0, 1, 0, 0, 8'h00, 1, 1, 0, 8'h00, 8'h00);
    drv(0, 1, 0, 0, 8'h00, 1, 1, 0, 8'h00, 8'h00);
    drv(0, 1, 0, 0, 8'h00, 0, 0, 1, 8'h00, 8'h00);
    drv(0, 1, 0, 0, 8'h00, 1, 0, 0, 8'h00, 8'h00);
    drv(0, 1, 0, 0, 8'h00, 1, 1, 1, 8'h59, 8'h23); // load beats en

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      int  r;
      bit  c, l, e, u, ce, cu, cl;
      logic [7:0] lv;
      r  = $urandom_range(0, 99);
      c  = (r < 4);
      l  = (r >= 4 && r < 18);
      e  = ($urandom_range(0, 3) != 0);
      u  = ($urandom_range(0, 4) != 0);
      lv = ($urandom_range(0, 1) != 0) ? bcd2($urandom_range(0, 59)) : 8'($urandom);
      ce = ($urandom_range(0, 3) != 0);
      cu = ($urandom_range(0, 5) != 0);
      cl = ($urandom_range(0, 39) == 0);
      drv(e, u, c, l, lv, ce, cu, cl,
          bcd2($urandom_range(55, 59)), bcd2($urandom_range(0, 23)));
    end
    idle();

    repeat (4) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
